// File: rtl/mem_port_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for a core sharing one unified single-port memory.
// Fetch-to-fetch 3 cycles (4 with load/store) at zero wait; stalls on mem_ready, traps to ERR after TIMEOUT waits.
module mem_port_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        stopflag,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_load,
    output logic        pc_en,
    output logic        rf_we_en,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] retired
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    // A miss on the TIMEOUT-th request cycle is fatal; a hit on it still succeeds.
    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [4:0]  wait_cnt;
    logic        we_q;
    logic [31:0] retired_q;
    logic        in_access;

    assign in_access = (state == S_FETCH) || (state == S_MEM);

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)                  next_state = S_EXEC;
                else if (wait_cnt == WAIT_LAST) next_state = S_ERR;
            end
            S_EXEC: begin
                if (stopflag)                    next_state = S_HALT;
                else if (mem_read || mem_write)  next_state = S_MEM;
                else                             next_state = S_WB;
            end
            S_MEM: begin
                if (mem_ready)                  next_state = S_WB;
                else if (wait_cnt == WAIT_LAST) next_state = S_ERR;
            end
            S_WB:    next_state = S_FETCH;
            S_HALT:  next_state = S_HALT;
            S_ERR:   next_state = S_ERR;
            default: next_state = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            wait_cnt  <= 5'd0;
            we_q      <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= 5'd0;
            else if (in_access && !mem_ready)
                wait_cnt <= wait_cnt + 5'd1;
            // A simultaneous read and write resolves to a write.
            if (state == S_EXEC)
                we_q <= mem_write;
            if (state == S_WB)
                retired_q <= retired_q + 32'd1;
        end
    end

    // Gating with rst keeps the bus quiet while reset holds the FSM in FETCH.
    assign mem_req  = rst && in_access;
    assign mem_we   = mem_req && (state == S_MEM) && we_q;
    assign addr_sel = rst && (state == S_MEM);
    assign ir_load  = rst && (state == S_FETCH) && mem_ready;
    assign pc_en    = rst && (state == S_WB);
    assign rf_we_en = rst && (state == S_WB);
    assign halted   = (state == S_HALT);
    assign bus_err  = (state == S_ERR);
    assign retired  = retired_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: per-cycle control-output vectors and retired count.
module tb_mem_port_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, stopflag, mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_load, pc_en, rf_we_en, halted, bus_err;
    logic [31:0] retired;
    logic [7:0]  outs;

    int n_assert = 0;
    int n_fail   = 0;

    // {mem_req, mem_we, addr_sel, ir_load, pc_en, rf_we_en, halted, bus_err}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_FW   = 8'b1000_0000;
    localparam logic [7:0] O_FR   = 8'b1001_0000;
    localparam logic [7:0] O_MRD  = 8'b1010_0000;
    localparam logic [7:0] O_MWR  = 8'b1110_0000;
    localparam logic [7:0] O_WB   = 8'b0000_1100;
    localparam logic [7:0] O_HALT = 8'b0000_0010;
    localparam logic [7:0] O_ERR  = 8'b0000_0001;

    mem_port_sequencer #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .stopflag  (stopflag),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_load   (ir_load),
        .pc_en     (pc_en),
        .rf_we_en  (rf_we_en),
        .halted    (halted),
        .bus_err   (bus_err),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    assign outs = {mem_req, mem_we, addr_sel, ir_load, pc_en, rf_we_en, halted, bus_err};

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance to just after the next edge.
    task automatic cyc(input logic rd, input logic wr, input logic st, input logic rdy,
                       input logic [7:0] exp, input string tag);
        mem_read  = rd;
        mem_write = wr;
        stopflag  = st;
        mem_ready = rdy;
        #1;
        chk8(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        stopflag  = 1'b0;
        mem_ready = 1'b1;
        #2;
        chk8("reset_outs", outs, O_NONE);
        chk32("reset_retired", retired, 32'd0);
        @(posedge clk);
        #1;
        chk8("reset_outs_edge", outs, O_NONE);
        rst = 1'b1;

        // Non-memory stream at zero wait: FETCH, EXEC, WB repeating.
        for (int i = 0; i < 30; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b1, (i % 3 == 0) ? O_FR : ((i % 3 == 1) ? O_NONE : O_WB), "addi");
        chk32("addi_retired", retired, 32'd10);

        // Load with two wait cycles in MEM.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_FR,   "ld_fetch");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_NONE, "ld_exec");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_MRD,  "ld_mem0");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_MRD,  "ld_mem1");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, O_MRD,  "ld_mem2");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_WB,   "ld_wb");
        chk32("ld_retired", retired, 32'd11);

        // Read+write together is a write; write flag is held from EXEC.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_FR,   "st_fetch");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, O_NONE, "st_exec");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_MWR,  "st_mem");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_WB,   "st_wb");
        chk32("st_retired", retired, 32'd12);

        // mem_ready on the 16th fetch request cycle still succeeds.
        for (int i = 0; i < 15; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, O_FW, "f16_wait");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_FR,   "f16_ok");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_NONE, "f16_exec");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_WB,   "f16_wb");
        chk32("f16_retired", retired, 32'd13);

        // Counter wrap.
        force dut.retired_q = 32'hFFFF_FFFE;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_FR, "wrap_fetch0");
        release dut.retired_q;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_NONE, "wrap_exec0");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_WB,   "wrap_wb0");
        chk32("wrap_max", retired, 32'hFFFF_FFFF);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_FR,   "wrap_fetch1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_NONE, "wrap_exec1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_WB,   "wrap_wb1");
        chk32("wrap_zero", retired, 32'd0);

        // One more instruction, then ECALL with mem_write set: halt, no MEM request.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_FR,   "pre_ecall_fetch");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_NONE, "pre_ecall_exec");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_WB,   "pre_ecall_wb");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_FR,   "ecall_fetch");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, O_NONE, "ecall_exec");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 1'b1, 1'b1, O_HALT, "halt_hold");
        chk32("halt_retired", retired, 32'd1);

        // Reset out of HALT.
        rst = 1'b0;
        #1;
        chk8("rst_halt_outs", outs, O_NONE);
        chk32("rst_halt_retired", retired, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_FR,   "post_halt_fetch");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_NONE, "post_halt_exec");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_WB,   "post_halt_wb");
        chk32("post_halt_retired", retired, 32'd1);

        // Reset mid-MEM aborts the access immediately.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_FR,   "abort_fetch");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, O_NONE, "abort_exec");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, O_MRD,  "abort_mem0");
        #1;
        chk8("abort_mem1", outs, O_MRD);
        #2;
        rst = 1'b0;
        #1;
        chk8("abort_rst_outs", outs, O_NONE);
        chk32("abort_rst_retired", retired, 32'd0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk8("abort_rst_held", outs, O_NONE);
        rst = 1'b1;

        // Fetch timeout: 16 unanswered request cycles, then terminal ERR.
        for (int i = 0; i < 16; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, O_FW, "fto_wait");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b1, O_ERR, "fto_err");
        chk32("fto_retired", retired, 32'd0);

        // Wait counter restarts on MEM entry; MEM then times out after 16 cycles.
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, O_FW, "mto_fwait");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_FR,   "mto_fetch");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, O_NONE, "mto_exec");
        for (int i = 0; i < 16; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, O_MWR, "mto_mwait");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, O_ERR, "mto_err");
        chk32("mto_retired", retired, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
